// File: rtl/hms_sevenseg_scan.sv
// hms_sevenseg_scan: multiplexed 8-digit active-low seven-segment driver for
// the HH.MM.SS timer. Scans six digits (5..0), one per REFRESH_DIV clocks,
// blinks the cursor digit in edit mode, and registers all display outputs.

// Binary 0..63 to tens/ones split for one time field.
module hms_bcd_split (
  input  logic [5:0] v,
  output logic [3:0] tens,
  output logic [3:0] ones
);
  // Constant-divisor divide/modulo; tens tops out at 6 for v = 63.
  always_comb begin
    tens = 4'(v / 6'd10);
    ones = 4'(v % 6'd10);
  end
endmodule

module hms_sevenseg_scan #(
  parameter int REFRESH_DIV = 100000,
  parameter int BLINK_TICKS = 125
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic [5:0] sec_i,
  input  logic [5:0] min_i,
  input  logic [5:0] hour_i,
  input  logic [2:0] digitp_i,
  input  logic       edit_i,
  output logic [7:0] an_o,
  output logic [6:0] seg_o,
  output logic       dp_o
);
  localparam int TW       = $clog2(REFRESH_DIV);
  localparam int BW       = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
  localparam int NUM_FLDS = 3;  // sec, min, hour

  typedef struct packed {
    logic [7:0] an;
    logic [6:0] seg;
    logic       dp;
  } disp_t;

  localparam disp_t DISP_OFF = '{an: 8'hFF, seg: 7'h7F, dp: 1'b1};

  logic [TW-1:0]                  tick;
  logic                           tick_end;
  logic [2:0]                     idx;
  logic [BW-1:0]                  slot;
  logic                           blink;
  logic [NUM_FLDS-1:0][5:0]       snap;
  logic [NUM_FLDS-1:0][3:0]       tens;
  logic [NUM_FLDS-1:0][3:0]       ones;
  logic [3:0]                     digit;
  logic                           blank;
  disp_t                          disp_nxt;
  disp_t                          disp_q;

  assign tick_end = (tick == TW'(REFRESH_DIV - 1));

  // Clock divider: one digit slot every REFRESH_DIV clocks.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i)       tick <= '0;
    else if (tick_end) tick <= '0;
    else               tick <= tick + TW'(1);
  end

  // Digit index 0..5, advanced at the end of each slot.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i)       idx <= '0;
    else if (tick_end) idx <= (idx == 3'd5) ? 3'd0 : idx + 3'd1;
  end

  // Blink phase: toggles every BLINK_TICKS completed slots.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      slot  <= '0;
      blink <= 1'b0;
    end else if (tick_end) begin
      if (slot == BW'(BLINK_TICKS - 1)) begin
        slot  <= '0;
        blink <= ~blink;
      end else begin
        slot  <= slot + BW'(1);
      end
    end
  end

  // Frame snapshot: one coherent time value per scan frame, taken at the
  // first clock of digit 0 so a frame never mixes old and new fields.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i)                     snap <= '0;
    else if (idx == 3'd0 && tick == '0) snap <= {hour_i, min_i, sec_i};
  end

  // One splitter per field; field f feeds digits 2f (ones) and 2f+1 (tens).
  for (genvar f = 0; f < NUM_FLDS; f++) begin : g_fld
    hms_bcd_split u_split (
      .v    (snap[f]),
      .tens (tens[f]),
      .ones (ones[f])
    );
  end

  // Pick the BCD digit for the slot being scanned.
  always_comb begin
    digit = '0;
    case (idx)
      3'd0:    digit = ones[0];
      3'd1:    digit = tens[0];
      3'd2:    digit = ones[1];
      3'd3:    digit = tens[1];
      3'd4:    digit = ones[2];
      3'd5:    digit = tens[2];
      default: digit = '0;
    endcase
  end

  // Cursor digit goes dark during the blink-on half period; edit/cursor are live.
  assign blank = edit_i & blink & (idx == digitp_i);

  // Next display word: anode, segment pattern and separator dot together.
  always_comb begin
    disp_nxt     = DISP_OFF;
    disp_nxt.an  = blank ? 8'hFF : ~(8'd1 << idx);
    disp_nxt.dp  = ~(idx == 3'd2 || idx == 3'd4);
    case (digit)
      4'd0:    disp_nxt.seg = 7'b1000000;
      4'd1:    disp_nxt.seg = 7'b1111001;
      4'd2:    disp_nxt.seg = 7'b0100100;
      4'd3:    disp_nxt.seg = 7'b0110000;
      4'd4:    disp_nxt.seg = 7'b0011001;
      4'd5:    disp_nxt.seg = 7'b0010010;
      4'd6:    disp_nxt.seg = 7'b0000010;
      4'd7:    disp_nxt.seg = 7'b1111000;
      4'd8:    disp_nxt.seg = 7'b0000000;
      4'd9:    disp_nxt.seg = 7'b0010000;
      default: disp_nxt.seg = 7'h7F;
    endcase
  end

  // Single output register so anode and segments switch on the same edge.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) disp_q <= DISP_OFF;
    else         disp_q <= disp_nxt;
  end

  assign an_o  = disp_q.an;
  assign seg_o = disp_q.seg;
  assign dp_o  = disp_q.dp;

endmodule

// File: tb/tb_hms_sevenseg_scan.sv
// Randomized + directed bench for hms_sevenseg_scan against a cycle-count
// reference model (slot/frame/blink derived arithmetically from time since reset).
module tb_hms_sevenseg_scan;
  localparam int RD    = 4;
  localparam int BT    = 6;
  localparam int FRAME = RD * 6;

  logic       clk = 1'b0;
  logic       reset_i;
  logic [5:0] sec_i, min_i, hour_i;
  logic [2:0] digitp_i;
  logic       edit_i;
  logic [7:0] an_o;
  logic [6:0] seg_o;
  logic       dp_o;

  hms_sevenseg_scan #(.REFRESH_DIV(RD), .BLINK_TICKS(BT)) dut (
    .clk_i    (clk),
    .reset_i  (reset_i),
    .sec_i    (sec_i),
    .min_i    (min_i),
    .hour_i   (hour_i),
    .digitp_i (digitp_i),
    .edit_i   (edit_i),
    .an_o     (an_o),
    .seg_o    (seg_o),
    .dp_o     (dp_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int k      = 0;        // edges since reset release
  int m_sec, m_min, m_hour;  // model snapshot
  logic [6:0] seg_tbl [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                               7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                               7'b0000000, 7'b0010000};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at edge %0d: got %0h expected %0h", tag, k, got, exp);
    end
  endtask

  task automatic chk_off(input string tag);
    check({tag, "_an"},  32'(an_o),  32'h0FF);
    check({tag, "_seg"}, 32'(seg_o), 32'h07F);
    check({tag, "_dp"},  32'(dp_o),  32'h1);
  endtask

  // One clock: model the state that the DUT held just before this edge.
  task automatic step();
    int c, slot, idx, blink, fld, d;
    logic [7:0] ea;
    logic [6:0] es;
    logic       ed;
    @(posedge clk);
    k++;
    c     = k - 1;
    slot  = c / RD;
    idx   = slot % 6;
    blink = (slot / BT) % 2;
    fld   = (idx / 2 == 0) ? m_sec : (idx / 2 == 1) ? m_min : m_hour;
    d     = (idx % 2 == 0) ? fld % 10 : fld / 10;
    es    = seg_tbl[d];
    ed    = (idx == 2 || idx == 4) ? 1'b0 : 1'b1;
    ea    = (edit_i && blink == 1 && idx == int'(digitp_i)) ? 8'hFF : ~(8'd1 << idx);
    if (c % FRAME == 0) begin
      m_sec  = int'(sec_i);
      m_min  = int'(min_i);
      m_hour = int'(hour_i);
    end
    #1;
    check("an",  32'(an_o),  32'(ea));
    check("seg", 32'(seg_o), 32'(es));
    check("dp",  32'(dp_o),  32'(ed));
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  // Advance until the next edge's pre-edge slot is idx == want.
  task automatic run_to_idx(input int want);
    int guard = 0;
    while (((k / RD) % 6) != want && guard < 64) begin
      step();
      guard++;
    end
    check("run_to_idx_bound", 32'(guard < 64), 32'h1);
  endtask

  task automatic set_time(input int h, input int m, input int s);
    hour_i = 6'(h);
    min_i  = 6'(m);
    sec_i  = 6'(s);
  endtask

  initial begin
    reset_i  = 1'b1;
    set_time(0, 0, 0);
    edit_i   = 1'b0;
    digitp_i = 3'd7;
    m_sec = 0; m_min = 0; m_hour = 0;

    // Reset held for 3 clocks
    repeat (3) begin
      @(posedge clk); #1;
      chk_off("rst_hold");
    end
    reset_i = 1'b0;
    k = 0;
    run(1);  // first edge: digit 0 from the cleared snapshot

    // Basic scan 12:05:37
    set_time(12, 5, 37);
    run(2 * FRAME);

    // Anti-tearing: sec 59 -> 0 while digit 3 is up
    sec_i = 6'd59;
    run(FRAME);
    run_to_idx(3);
    sec_i = 6'd0;
    run(2 * FRAME);

    // Blink on digit 3, then no-digit cursor, then edit off
    edit_i = 1'b1; digitp_i = 3'd3;
    run(4 * BT * RD);
    digitp_i = 3'd6;
    run(2 * BT * RD);
    digitp_i = 3'd7;
    run(BT * RD);
    digitp_i = 3'd3;
    run(BT * RD + 3);
    edit_i = 1'b0;
    run(2 * BT * RD);

    // Out-of-range hour and max time
    set_time(63, 0, 0);
    run(2 * FRAME);
    set_time(23, 59, 59);
    run(2 * FRAME);

    // Asynchronous reset pulse in the middle of digit 3
    run_to_idx(3);
    run(1);
    @(negedge clk); #1;
    reset_i = 1'b1;
    #1;
    chk_off("rst_async");
    #10;
    chk_off("rst_async_hold");
    reset_i = 1'b0;
    k = 0;
    m_sec = 0; m_min = 0; m_hour = 0;
    run(2 * FRAME);

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(19) == 0) sec_i  = 6'($urandom_range(63));
      if ($urandom_range(29) == 0) min_i  = 6'($urandom_range(63));
      if ($urandom_range(39) == 0) hour_i = 6'($urandom_range(63));
      if ($urandom_range(49) == 0) edit_i = ~edit_i;
      if ($urandom_range(59) == 0) digitp_i = 3'($urandom_range(7));
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/hms_sevenseg_scan.md
Name: hms_sevenseg_scan

Overview:
- Display stage directly downstream of the hour/minute/second timer.
- Consumes the timer's binary `sec`/`min`/`hour` values and its edit cursor position (`digitp`).
- Drives a multiplexed, active-low, 8-digit seven-segment display. The six time digits are laid out HH.MM.SS on digits 5..0; digits 6 and 7 stay dark.
- While editing, the digit under the cursor blinks.

Parameters:
- REFRESH_DIV, 100000: clocks per digit slot (1 kHz digit rate at 100 MHz). Legal range ≥ 2.
- BLINK_TICKS, 125: digit slots per blink half-period. Legal range ≥ 1.

Ports:
- clk_i  input  1  system clock
- reset_i  input  1  asynchronous, active-high reset
- sec_i  input  6  seconds, binary, 0..63 accepted
- min_i  input  6  minutes, binary, 0..63 accepted
- hour_i  input  6  hours, binary, 0..63 accepted
- digitp_i  input  3  cursor digit index 0..5; 6 and 7 mean no digit selected
- edit_i  input  1  1 = edit mode, blink the cursor digit
- an_o  output  8  anode enables, active-low, bit n = digit n
- seg_o  output  7  segments {g,f,e,d,c,b,a}, active-low
- dp_o  output  1  decimal point, active-low

Behaviour:
- **Reset.** One clock domain; reset is asynchronous and active-high. While reset_i = 1:
  - tick = 0, idx = 0, blink = 0, all snapshot registers = 0.
  - an_o = 8'hFF, seg_o = 7'h7F, dp_o = 1.
  - Reset asserted mid-frame forces these values immediately, with no clock edge needed.
- **Tick counter.** Counts 0..REFRESH_DIV-1 and wraps. At terminal count, idx advances 0→1→…→5→0.
- **Blink phase.** A slot counter counts digit-slot ends 0..BLINK_TICKS-1. On its wrap, `blink` toggles.
- **Snapshot.**
  - sec_i, min_i and hour_i are loaded into snapshot registers on every cycle where idx == 0 and tick == 0. This includes the first clock after reset deasserts.
  - All six digits of a frame come from one snapshot. Input changes mid-frame are not visible until the next frame.
- **Digit split.** Per field: tens = v/10, ones = v%10, for v = 0..63. Tens can be 0..6.
  - Mapping: idx0 = sec ones, idx1 = sec tens, idx2 = min ones, idx3 = min tens, idx4 = hour ones, idx5 = hour tens.
  - No leading-zero suppression.
- **Segment codes (gfedcba, active-low):**
  - 0 = 1000000
  - 1 = 1111001
  - 2 = 0100100
  - 3 = 0110000
  - 4 = 0011001
  - 5 = 0010010
  - 6 = 0000010
  - 7 = 1111000
  - 8 = 0000000
  - 9 = 0010000
- **Decimal point.** dp_o = 0 when idx is 2 or 4 (separators); dp_o = 1 otherwise.
- **Anode.** an_o = ~(8'b1 << idx).
  - Blank rule: when edit_i = 1, blink = 1 and idx == digitp_i, force an_o = 8'hFF.
  - edit_i and digitp_i are sampled live (not snapshotted).
- **Latency.** an_o, seg_o and dp_o are registered. They reflect (idx, snapshot, blink, edit_i, digitp_i) from the previous clock, i.e. 1-clock latency.
  - Each digit is therefore shown for exactly REFRESH_DIV clocks, offset one clock from the idx change.
- **Glitch-free outputs.** An anode change and its segment change occur on the same edge; no intermediate values.
- **Boundary cases.**
  - digitp_i = 6 or 7: nothing blanks.
  - edit_i falling while blanked: the digit reappears on the next registered update.
  - Terminal tick coinciding with the snapshot cycle: the snapshot uses values sampled at that edge.

Test Plan (REFRESH_DIV = 4, BLINK_TICKS = 6):
1. **Reset.** Hold reset_i for 3 clocks → an_o = FF, seg_o = 7F, dp_o = 1. Release → on clock 1, an_o = FE and seg_o = 1000000 (snapshot 0). Pulse reset_i for 12 ns mid-idx 3 → outputs return to FF/7F/1 asynchronously.
2. **Basic scan.** sec = 37, min = 5, hour = 12, edit_i = 0 → anodes FE, FD, FB, F7, EF, DF, each for 4 clocks, repeating.
   - seg_o sequence: 1111000, 0110000, 0010010, 1000000, 0100100, 1111001.
   - dp_o = 0 only during FB and EF.
3. **Anti-tearing.** Change sec from 59 to 0 while idx = 3 → the rest of the frame shows old min/hour, and digits 0/1 of the next frame show 0,0. No mixed frame is observed.
4. **Blink.** edit_i = 1, digitp_i = 3 → digit 3 slot shows an_o = FF during alternate 6-slot windows (blink = 1) and F7 otherwise.
   - Other digits are unaffected.
   - Repeat with digitp_i = 6 → no blanking. Repeat with edit_i = 0 → no blanking.
5. **Out-of-range value.** hour = 63, min = 0, sec = 0 → idx5 seg = 0000010 ('6'), idx4 seg = 0110000 ('3').
6. **Max time.** hour = 23, min = 59, sec = 59 → digits 0..5 show 9, 5, 9, 5, 3, 2 with the correct codes.
